sc_pos_updown_counter: RTL and testbench
========================================

SC_POS_UPDOWN_COUNTER -- requirements
Module: sc_pos_updown_counter

Interface
REQ-001 Parameter: posCOUNTER_DATAWIDTH, default 3, width of the count bus (range 1..16).
REQ-002 Parameter: posCOUNTER_MODULUS, default 8, number of count states 0..MODULUS-1 (range 2..2**DATAWIDTH).
REQ-003 Port: SC_posUPDOWN_CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: SC_posUPDOWN_RESET_InLow  input  1  reset, synchronous, active-low.
REQ-005 Port: SC_posUPDOWN_upcount_InLow  input  1  count-up request, active-low.
REQ-006 Port: SC_posUPDOWN_downcount_InLow  input  1  count-down request, active-low.
REQ-007 Port: SC_posUPDOWN_load_InLow  input  1  parallel-load request, active-low.
REQ-008 Port: SC_posUPDOWN_data_InBUS  input  DATAWIDTH  load value.
REQ-009 Port: SC_posUPDOWN_data_OutBUS  output  DATAWIDTH  current count, driven directly from the state register.
REQ-010 Port: SC_posUPDOWN_wrap_Out  output  1  registered one-cycle event pulse (see REQ-017/REQ-025).
REQ-011 Port: SC_posUPDOWN_zero_Out  output  1  high while the count equals 0 (combinational from the register).

Function
REQ-012 Command priority per cycle SHALL be: reset > load > (up AND down asserted together = hold) > up > down > hold.
REQ-013 Load SHALL write data_InBUS into the count on the next edge, clamped to MODULUS-1 when data_InBUS >= MODULUS.
REQ-014 Up SHALL increment the count by 1 on the next edge (latency 1 cycle).
REQ-015 Down SHALL decrement the count by 1 on the next edge (latency 1 cycle).
REQ-016 Wrap mode (macro absent): up at MODULUS-1 -> 0; down at 0 -> MODULUS-1.
REQ-017 Wrap mode: wrap_Out SHALL be 1 for exactly the cycle following an edge where a wrap occurred, otherwise 0.
REQ-018 Load SHALL never assert wrap_Out, including a clamped load.
REQ-019 Held requests SHALL count once per clock; wrap_Out SHALL pulse on every wrap during continuous counting.
REQ-020 Arithmetic SHALL be performed at DATAWIDTH+1 bits internally; the count SHALL never hold a value >= MODULUS.

Reset
REQ-021 When RESET_InLow = 0 at a rising clock edge: count <= 0, wrap_Out <= 0; zero_Out = 1 thereafter.
REQ-022 Reset SHALL override any simultaneous load/up/down; no wrap pulse is generated by reset.
REQ-023 Reset deasserted mid-sequence: counting SHALL resume from 0 at the first edge with RESET_InLow = 1 and an active request.
REQ-024 No asynchronous behaviour; reset is sampled only on the clock edge.

Configuration
REQ-025 Macro SC_POSCOUNTER_SATURATE_EN defined: up at MODULUS-1 and down at 0 SHALL hold the count (saturate); wrap_Out SHALL pulse one cycle for each request blocked at a limit.
REQ-026 Macro undefined: wrap behaviour per REQ-016/REQ-017; no saturation logic SHALL be synthesised.

Structure
REQ-027 Package sc_poscounter_pkg SHALL hold the command encoding (CMD_HOLD, CMD_LOAD, CMD_UP, CMD_DOWN) and the default DATAWIDTH/MODULUS constants.
REQ-028 Sub-module sc_poscounter_nextval SHALL hold the combinational next-value/event logic (inputs: command, count, load value; outputs: next count, event); the top holds the priority decoder and state registers only.
REQ-029 Out-of-range parameters (MODULUS < 2 or > 2**DATAWIDTH) SHALL cause an elaboration-time error.

Verification
REQ-030 Defaults, reset low 2 cycles, then up held 9 cycles -> count 1..7,0,1; wrap_Out high the single cycle count shows 0; zero_Out high at reset and at 0.
REQ-031 MODULUS=5, down from 0 -> count 4, wrap_Out pulses once; down x4 more -> 3,2,1,0, no pulse.
REQ-032 Load 6 with MODULUS=5 and up asserted same cycle -> count 4 (clamped, load wins), wrap_Out 0.
REQ-033 Up and down asserted together at count 3 -> count stays 3, wrap_Out 0; reset asserted same cycle as load 5 -> count 0.
REQ-034 SC_POSCOUNTER_SATURATE_EN defined, defaults: up held at 7 for 3 cycles -> count stays 7, wrap_Out high 3 cycles; down at 0 -> stays 0, wrap_Out pulses.
REQ-035 Reset pulsed low for 1 cycle mid-count at 5 with up held -> count 0 on that edge, then 1, 2 on following edges.

Source files
------------

// File: rtl/sc_poscounter_pkg.sv
// Shared command encoding and default sizing for the modulo up/down counter.
package sc_poscounter_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_UP   = 2'd2,
        CMD_DOWN = 2'd3
    } cmd_t;

    localparam int DEFAULT_DATAWIDTH = 3;
    localparam int DEFAULT_MODULUS   = 8;

endpackage

// File: rtl/sc_poscounter_nextval.sv
// Combinational next-count and wrap/limit event for one command.
// Define SC_POSCOUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module sc_poscounter_nextval
    import sc_poscounter_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int MODULUS   = DEFAULT_MODULUS
) (
    input  cmd_t                 cmd,
    input  logic [DATAWIDTH-1:0] count,
    input  logic [DATAWIDTH-1:0] load_value,
    output logic [DATAWIDTH-1:0] next_count,
    output logic                 wrap_event
);

    // One spare bit lets MODULUS itself and the up/down carries be represented.
    localparam logic [DATAWIDTH:0] MODULUS_EXT = (DATAWIDTH+1)'(MODULUS);
    localparam logic [DATAWIDTH:0] MAX_EXT     = (DATAWIDTH+1)'(MODULUS - 1);
    localparam logic [DATAWIDTH:0] ONE_EXT     = (DATAWIDTH+1)'(1);

    logic [DATAWIDTH:0] count_ext;
    logic [DATAWIDTH:0] load_ext;
    logic [DATAWIDTH:0] inc_ext;
    logic [DATAWIDTH:0] dec_ext;

    assign count_ext = {1'b0, count};
    assign load_ext  = {1'b0, load_value};
    assign inc_ext   = count_ext + ONE_EXT;
    assign dec_ext   = count_ext - ONE_EXT;

    always_comb begin
        next_count = count;
        wrap_event = 1'b0;
        case (cmd)
            CMD_LOAD: begin
                if (load_ext >= MODULUS_EXT) begin
                    next_count = MAX_EXT[DATAWIDTH-1:0];
                end else begin
                    next_count = load_ext[DATAWIDTH-1:0];
                end
            end
            CMD_UP: begin
                if (inc_ext >= MODULUS_EXT) begin
                    wrap_event = 1'b1;
`ifdef SC_POSCOUNTER_SATURATE_EN
                    next_count = count;
`else
                    next_count = '0;
`endif
                end else begin
                    next_count = inc_ext[DATAWIDTH-1:0];
                end
            end
            CMD_DOWN: begin
                // The borrow bit is set only when stepping down from zero.
                if (dec_ext[DATAWIDTH]) begin
                    wrap_event = 1'b1;
`ifdef SC_POSCOUNTER_SATURATE_EN
                    next_count = count;
`else
                    next_count = MAX_EXT[DATAWIDTH-1:0];
`endif
                end else begin
                    next_count = dec_ext[DATAWIDTH-1:0];
                end
            end
            default: begin
                next_count = count;
                wrap_event = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sc_pos_updown_counter.sv
// Modulo up/down counter with clamped parallel load and a registered wrap pulse.
// Define SC_POSCOUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module sc_pos_updown_counter
    import sc_poscounter_pkg::*;
#(
    parameter int posCOUNTER_DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int posCOUNTER_MODULUS   = DEFAULT_MODULUS
) (
    input  logic                            SC_posUPDOWN_CLOCK_50,
    input  logic                            SC_posUPDOWN_RESET_InLow,
    input  logic                            SC_posUPDOWN_upcount_InLow,
    input  logic                            SC_posUPDOWN_downcount_InLow,
    input  logic                            SC_posUPDOWN_load_InLow,
    input  logic [posCOUNTER_DATAWIDTH-1:0] SC_posUPDOWN_data_InBUS,
    output logic [posCOUNTER_DATAWIDTH-1:0] SC_posUPDOWN_data_OutBUS,
    output logic                            SC_posUPDOWN_wrap_Out,
    output logic                            SC_posUPDOWN_zero_Out
);

    if (posCOUNTER_DATAWIDTH < 1 || posCOUNTER_DATAWIDTH > 16) begin : g_bad_width
        $error("sc_pos_updown_counter: posCOUNTER_DATAWIDTH must be 1..16");
    end
    if (posCOUNTER_MODULUS < 2 ||
        posCOUNTER_MODULUS > (1 << posCOUNTER_DATAWIDTH)) begin : g_bad_modulus
        $error("sc_pos_updown_counter: posCOUNTER_MODULUS must be 2..2**DATAWIDTH");
    end

    cmd_t                            cmd;
    logic [posCOUNTER_DATAWIDTH-1:0] count;
    logic [posCOUNTER_DATAWIDTH-1:0] next_count;
    logic                            wrap_event;
    logic                            wrap_q;

    // Load beats counting; up and down together cancel to a hold.
    always_comb begin
        cmd = CMD_HOLD;
        if (!SC_posUPDOWN_load_InLow) begin
            cmd = CMD_LOAD;
        end else if (!SC_posUPDOWN_upcount_InLow && !SC_posUPDOWN_downcount_InLow) begin
            cmd = CMD_HOLD;
        end else if (!SC_posUPDOWN_upcount_InLow) begin
            cmd = CMD_UP;
        end else if (!SC_posUPDOWN_downcount_InLow) begin
            cmd = CMD_DOWN;
        end
    end

    sc_poscounter_nextval #(
        .DATAWIDTH (posCOUNTER_DATAWIDTH),
        .MODULUS   (posCOUNTER_MODULUS)
    ) u_nextval (
        .cmd        (cmd),
        .count      (count),
        .load_value (SC_posUPDOWN_data_InBUS),
        .next_count (next_count),
        .wrap_event (wrap_event)
    );

    always_ff @(posedge SC_posUPDOWN_CLOCK_50) begin
        if (!SC_posUPDOWN_RESET_InLow) begin
            count  <= '0;
            wrap_q <= 1'b0;
        end else begin
            count  <= next_count;
            wrap_q <= wrap_event;
        end
    end

    assign SC_posUPDOWN_data_OutBUS = count;
    assign SC_posUPDOWN_wrap_Out    = wrap_q;
    assign SC_posUPDOWN_zero_Out    = (count == '0);

endmodule

// File: tb/tb_sc_pos_updown_counter.sv
// Bench for sc_pos_updown_counter: a modulus-8 and a modulus-5 instance share stimulus
// and are checked against an arithmetic model (honours SC_POSCOUNTER_SATURATE_EN).
module tb_sc_pos_updown_counter;

    logic       clk;
    logic       reset_n;
    logic       up_n;
    logic       down_n;
    logic       load_n;
    logic [2:0] data;

    logic [2:0] count8;
    logic       wrap8;
    logic       zero8;
    logic [2:0] count5;
    logic       wrap5;
    logic       zero5;

    int vectors;
    int miscompares;
    int model8;
    int model5;
    bit mwrap8;
    bit mwrap5;

    sc_pos_updown_counter dut8 (
        .SC_posUPDOWN_CLOCK_50        (clk),
        .SC_posUPDOWN_RESET_InLow     (reset_n),
        .SC_posUPDOWN_upcount_InLow   (up_n),
        .SC_posUPDOWN_downcount_InLow (down_n),
        .SC_posUPDOWN_load_InLow      (load_n),
        .SC_posUPDOWN_data_InBUS      (data),
        .SC_posUPDOWN_data_OutBUS     (count8),
        .SC_posUPDOWN_wrap_Out        (wrap8),
        .SC_posUPDOWN_zero_Out        (zero8)
    );

    sc_pos_updown_counter #(
        .posCOUNTER_DATAWIDTH (3),
        .posCOUNTER_MODULUS   (5)
    ) dut5 (
        .SC_posUPDOWN_CLOCK_50        (clk),
        .SC_posUPDOWN_RESET_InLow     (reset_n),
        .SC_posUPDOWN_upcount_InLow   (up_n),
        .SC_posUPDOWN_downcount_InLow (down_n),
        .SC_posUPDOWN_load_InLow      (load_n),
        .SC_posUPDOWN_data_InBUS      (data),
        .SC_posUPDOWN_data_OutBUS     (count5),
        .SC_posUPDOWN_wrap_Out        (wrap5),
        .SC_posUPDOWN_zero_Out        (zero5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter behaviour written directly as modular arithmetic on an integer.
    task automatic model_step(input int modulus, input bit rst, input bit ld, input bit up,
                              input bit dn, input int value, input int cnt_in,
                              output int cnt_out, output bit wrap);
        cnt_out = cnt_in;
        wrap    = 1'b0;
        if (rst) begin
            cnt_out = 0;
        end else if (ld) begin
            cnt_out = (value >= modulus) ? modulus - 1 : value;
        end else if (up && !dn) begin
`ifdef SC_POSCOUNTER_SATURATE_EN
            if (cnt_in == modulus - 1) wrap = 1'b1;
            else cnt_out = cnt_in + 1;
`else
            cnt_out = (cnt_in + 1) % modulus;
            wrap    = (cnt_out == 0);
`endif
        end else if (dn && !up) begin
`ifdef SC_POSCOUNTER_SATURATE_EN
            if (cnt_in == 0) wrap = 1'b1;
            else cnt_out = cnt_in - 1;
`else
            cnt_out = (cnt_in + modulus - 1) % modulus;
            wrap    = (cnt_out == modulus - 1);
`endif
        end
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of active-high requests, clock it, advance the model, compare both DUTs.
    task automatic apply_stimulus(input bit rst, input bit ld, input bit up, input bit dn,
                                  input int value);
        int  n8;
        int  n5;
        reset_n = ~rst;
        load_n  = ~ld;
        up_n    = ~up;
        down_n  = ~dn;
        data    = value[2:0];
        @(posedge clk);
        #1;
        model_step(8, rst, ld, up, dn, value, model8, n8, mwrap8);
        model_step(5, rst, ld, up, dn, value, model5, n5, mwrap5);
        model8 = n8;
        model5 = n5;
        check_output("count8", {13'd0, count8}, 16'(model8));
        check_output("wrap8",  {15'd0, wrap8},  {15'd0, mwrap8});
        check_output("zero8",  {15'd0, zero8},  {15'd0, model8 == 0});
        check_output("count5", {13'd0, count5}, 16'(model5));
        check_output("wrap5",  {15'd0, wrap5},  {15'd0, mwrap5});
        check_output("zero5",  {15'd0, zero5},  {15'd0, model5 == 0});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model8      = 0;
        model5      = 0;
        reset_n     = 1'b0;
        up_n        = 1'b1;
        down_n      = 1'b1;
        load_n      = 1'b1;
        data        = 3'd0;

        // Reset two cycles, with up requested to show reset overrides it.
        apply_stimulus(1, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);

        // Up held nine cycles: 1..7,0,1 on the default instance.
        for (int i = 0; i < 9; i++) apply_stimulus(0, 0, 1, 0, 0);

        // Back to zero, then down from zero and four more downs.
        apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 1, 0);

        // Clamped load with up asserted at the same time.
        apply_stimulus(0, 1, 1, 0, 6);
        apply_stimulus(0, 0, 0, 0, 0);

        // Up and down together hold the count.
        apply_stimulus(0, 1, 0, 0, 3);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 1, 1, 0);

        // Reset wins over a simultaneous load.
        apply_stimulus(1, 1, 0, 0, 5);

        // Reset pulse mid-count with up held.
        apply_stimulus(0, 1, 0, 0, 5);
        apply_stimulus(1, 0, 1, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0);

        // Up held at the top limit, then down at zero.
        apply_stimulus(0, 1, 0, 0, 7);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);

        // Randomised traffic with rare resets and loads.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
                           int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
